// File: rtl/ads1675_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ads1675_pkg
// Brief    : Shared types and constants for the ADS1675 control sequencer.
// Revision : 1.0  initial release
// ============================================================================
package ads1675_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PWRUP   = 3'd1,
    SETTLE  = 3'd2,
    RUN     = 3'd3,
    RESTART = 3'd4
  } ads1675_state_e;

  typedef logic [2:0] drate_t;

  // DRATE pin codes, fastest to slowest output data rate
  localparam drate_t c_DRATE_4M   = 3'b000;
  localparam drate_t c_DRATE_2M   = 3'b001;
  localparam drate_t c_DRATE_1M   = 3'b010;
  localparam drate_t c_DRATE_500K = 3'b011;
  localparam drate_t c_DRATE_250K = 3'b100;
  localparam drate_t c_DRATE_125K = 3'b101;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ads1675_ctrl_timer.sv
`default_nettype none
// ============================================================================
// Module   : ads1675_ctrl_timer
// Brief    : Loadable down-counter shared by every wait phase of the sequencer;
//            holds at zero once it gets there.
// Revision : 1.0  initial release
// ============================================================================
module ads1675_ctrl_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  output logic [TW-1:0] o_value,
  output logic          o_zero
);

  logic [TW-1:0] r_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_val <= '0;
    end else if (i_load) begin
      r_val <= i_load_val;
    end else if (r_val != '0) begin
      r_val <= r_val - 1'b1;
    end
  end

  assign o_value = r_val;
  assign o_zero  = (r_val == '0);

endmodule
`default_nettype wire

// File: rtl/ads1675_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ads1675_ctrl
// Brief    : ADS1675 power-up / run sequencer with settle gating, stall
//            recovery and controlled data-rate restarts.
//            Optional: ADS1675_CTRL_STATS_EN builds sample/restart counters.
// Revision : 1.0  initial release
// ============================================================================
module ads1675_ctrl
  import ads1675_pkg::*;
#(
  parameter int W           = 24,
  parameter int PWR_WAIT    = 1000,
  parameter int SETTLE_WAIT = 2048,
  parameter int TIMEOUT     = 256,
  parameter int RESTART_LOW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [2:0]   drate_cfg,
  input  logic         ll_cfg,
  input  logic         cfg_update,
  input  logic         err_clr,
  input  logic         rx_valid,
  input  logic [W-1:0] rx_data,
  output logic         pdwn_n,
  output logic         start,
  output logic [2:0]   drate,
  output logic         ll_config,
  output logic         rx_en,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         ready,
  output logic         timeout_err,
  output logic [2:0]   state,
  output logic [31:0]  sample_cnt,
  output logic [15:0]  restart_cnt
);

  localparam int c_TMR_W = $clog2(max_int(max_int(PWR_WAIT, SETTLE_WAIT),
                                          max_int(TIMEOUT, RESTART_LOW))) + 1;

  // A phase loaded with N-1 lasts exactly N cycles before the zero flag fires
  localparam logic [c_TMR_W-1:0] c_LD_PWR     = c_TMR_W'(PWR_WAIT - 1);
  localparam logic [c_TMR_W-1:0] c_LD_SETTLE  = c_TMR_W'(SETTLE_WAIT - 1);
  localparam logic [c_TMR_W-1:0] c_LD_TIMEOUT = c_TMR_W'(TIMEOUT - 1);
  localparam logic [c_TMR_W-1:0] c_LD_RESTART = c_TMR_W'(RESTART_LOW - 1);

  ads1675_state_e r_state;
  ads1675_state_e w_state_nxt;

  logic               w_tmr_load;
  logic [c_TMR_W-1:0] w_tmr_val;
  logic [c_TMR_W-1:0] w_tmr_value;
  logic               w_tmr_zero;
  logic               w_unused_tmr;

  logic               w_fwd;
  logic               w_timeout;
  logic               w_cfg_latch;

  logic               r_pdwn_n,   w_pdwn_nxt;
  logic               r_start,    w_start_nxt;
  logic               r_rx_en,    w_rx_en_nxt;
  logic               r_ready,    w_ready_nxt;
  logic               r_out_valid, w_out_valid_nxt;
  logic [W-1:0]       r_out_data, w_out_data_nxt;
  drate_t             r_drate,    w_drate_nxt;
  logic               r_ll,       w_ll_nxt;
  logic               r_err,      w_err_nxt;

  ads1675_ctrl_timer #(
    .TW (c_TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_value    (w_tmr_value),
    .o_zero     (w_tmr_zero)
  );

  assign w_unused_tmr = ^w_tmr_value;

  // en low overrides every other event, so each qualifier includes it
  assign w_fwd       = en && (r_state == RUN) && rx_valid;
  assign w_timeout   = en && (r_state == RUN) && w_tmr_zero && !rx_valid;
  assign w_cfg_latch = en && ((r_state == IDLE) || cfg_update);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    if (!en) begin
      w_state_nxt = IDLE;
      w_tmr_load  = 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nxt = PWRUP;
          w_tmr_load  = 1'b1;
          w_tmr_val   = c_LD_PWR;
        end
        PWRUP: begin
          if (w_tmr_zero) begin
            w_state_nxt = SETTLE;
            w_tmr_load  = 1'b1;
            w_tmr_val   = c_LD_SETTLE;
          end
        end
        SETTLE: begin
          if (w_tmr_zero) begin
            w_state_nxt = RUN;
            w_tmr_load  = 1'b1;
            w_tmr_val   = c_LD_TIMEOUT;
          end
        end
        RUN: begin
          if (cfg_update || w_timeout) begin
            w_state_nxt = RESTART;
            w_tmr_load  = 1'b1;
            w_tmr_val   = c_LD_RESTART;
          end else if (rx_valid) begin
            w_tmr_load  = 1'b1;
            w_tmr_val   = c_LD_TIMEOUT;
          end
        end
        RESTART: begin
          if (w_tmr_zero) begin
            w_state_nxt = SETTLE;
            w_tmr_load  = 1'b1;
            w_tmr_val   = c_LD_SETTLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_tmr_load  = 1'b1;
        end
      endcase
    end
  end

  // Pin levels follow the state being entered, so they register alongside it
  always_comb begin
    w_pdwn_nxt      = (w_state_nxt != IDLE);
    w_start_nxt     = (w_state_nxt == SETTLE) || (w_state_nxt == RUN);
    w_rx_en_nxt     = (w_state_nxt != IDLE) && (w_state_nxt != PWRUP);
    w_ready_nxt     = (w_state_nxt == RUN);
    w_out_valid_nxt = w_fwd;
    w_out_data_nxt  = w_fwd ? rx_data : r_out_data;
    w_drate_nxt     = w_cfg_latch ? drate_t'(drate_cfg) : r_drate;
    w_ll_nxt        = w_cfg_latch ? ll_cfg : r_ll;
    w_err_nxt       = r_err;
    if (w_timeout) begin
      w_err_nxt = 1'b1;
    end else if (err_clr) begin
      w_err_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pdwn_n    <= 1'b0;
      r_start     <= 1'b0;
      r_rx_en     <= 1'b0;
      r_ready     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_drate     <= c_DRATE_4M;
      r_ll        <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_pdwn_n    <= w_pdwn_nxt;
      r_start     <= w_start_nxt;
      r_rx_en     <= w_rx_en_nxt;
      r_ready     <= w_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_drate     <= w_drate_nxt;
      r_ll        <= w_ll_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign pdwn_n      = r_pdwn_n;
  assign start       = r_start;
  assign rx_en       = r_rx_en;
  assign ready       = r_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign drate       = r_drate;
  assign ll_config   = r_ll;
  assign timeout_err = r_err;
  assign state       = r_state;

`ifdef ADS1675_CTRL_STATS_EN
  logic [31:0] r_sample_cnt;
  logic [15:0] r_restart_cnt;
  logic        w_restart_entry;

  assign w_restart_entry = (r_state == RUN) && (w_state_nxt == RESTART);

  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      r_sample_cnt  <= '0;
      r_restart_cnt <= '0;
    end else begin
      if (w_fwd && (r_sample_cnt != '1)) begin
        r_sample_cnt <= r_sample_cnt + 32'd1;
      end
      if (w_restart_entry && (r_restart_cnt != '1)) begin
        r_restart_cnt <= r_restart_cnt + 16'd1;
      end
    end
  end

  assign sample_cnt  = r_sample_cnt;
  assign restart_cnt = r_restart_cnt;
`else
  assign sample_cnt  = '0;
  assign restart_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ads1675_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ads1675_ctrl
// Brief    : Scoreboard bench for ads1675_ctrl: directed sequences plus random
//            traffic against an event/deadline reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ads1675_ctrl;

  localparam int W           = 24;
  localparam int PWR_WAIT    = 8;
  localparam int SETTLE_WAIT = 16;
  localparam int TIMEOUT     = 20;
  localparam int RESTART_LOW = 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PWRUP   = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_RESTART = 3'd4;

  logic         clk = 1'b0;
  logic         rst, en, cfg_update, err_clr, rx_valid, ll_cfg;
  logic [2:0]   drate_cfg;
  logic [W-1:0] rx_data;
  logic         pdwn_n, start, ll_config, rx_en, out_valid, ready, timeout_err;
  logic [2:0]   drate, state;
  logic [W-1:0] out_data;
  logic [31:0]  sample_cnt;
  logic [15:0]  restart_cnt;

  ads1675_ctrl #(
    .W (W), .PWR_WAIT (PWR_WAIT), .SETTLE_WAIT (SETTLE_WAIT),
    .TIMEOUT (TIMEOUT), .RESTART_LOW (RESTART_LOW)
  ) dut (
    .clk (clk), .rst (rst), .en (en), .drate_cfg (drate_cfg), .ll_cfg (ll_cfg),
    .cfg_update (cfg_update), .err_clr (err_clr), .rx_valid (rx_valid),
    .rx_data (rx_data), .pdwn_n (pdwn_n), .start (start), .drate (drate),
    .ll_config (ll_config), .rx_en (rx_en), .out_valid (out_valid),
    .out_data (out_data), .ready (ready), .timeout_err (timeout_err),
    .state (state), .sample_cnt (sample_cnt), .restart_cnt (restart_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pdwn_n;
    logic        start;
    logic        rx_en;
    logic        ready;
    logic        out_valid;
    logic        timeout_err;
    logic        ll_config;
    logic [2:0]  drate;
    logic [2:0]  state;
    logic [31:0] scnt;
    logic [15:0] rcnt;
  } ctl_t;

  ctl_t         ctl_q[$];
  logic [W-1:0] data_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  // Reference model: phases end at absolute cycle deadlines
  logic [2:0] m_phase = S_IDLE;
  int         m_end   = 0;
  int         m_last  = 0;
  int         cyc     = 0;
  bit         m_pdwn, m_start, m_rxen, m_ready, m_err, m_ll, m_ov;
  bit [2:0]   m_drate;
  longint     m_scnt;
  longint     m_rcnt;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic void take_cfg();
    m_drate = drate_cfg;
    m_ll    = ll_cfg;
  endfunction

  function automatic void model_edge();
    bit   tmo = 0;
    ctl_t e;
    m_ov = 0;
    if (rst) begin
      m_phase = S_IDLE; m_pdwn = 0; m_start = 0; m_rxen = 0; m_ready = 0;
      m_err = 0; m_ll = 0; m_drate = 0; m_scnt = 0; m_rcnt = 0;
    end else begin
      if (!en) begin
        m_phase = S_IDLE; m_pdwn = 0; m_start = 0; m_rxen = 0; m_ready = 0;
      end else begin
        case (m_phase)
          S_IDLE: begin
            take_cfg(); m_pdwn = 1; m_phase = S_PWRUP; m_end = cyc + PWR_WAIT;
          end
          S_PWRUP: begin
            if (cfg_update) take_cfg();
            if (cyc >= m_end) begin
              m_start = 1; m_rxen = 1; m_phase = S_SETTLE; m_end = cyc + SETTLE_WAIT;
            end
          end
          S_SETTLE: begin
            if (cfg_update) take_cfg();
            if (cyc >= m_end) begin
              m_ready = 1; m_phase = S_RUN; m_last = cyc;
            end
          end
          S_RUN: begin
            if (rx_valid) begin
              m_ov = 1; data_q.push_back(rx_data); m_last = cyc;
              if (m_scnt < 64'hFFFF_FFFF) m_scnt++;
            end else if (cyc - m_last >= TIMEOUT) begin
              tmo = 1;
            end
            if (cfg_update || tmo) begin
              if (cfg_update) take_cfg();
              m_start = 0; m_ready = 0; m_phase = S_RESTART; m_end = cyc + RESTART_LOW;
              if (m_rcnt < 64'hFFFF) m_rcnt++;
            end
          end
          default: begin
            if (cfg_update) take_cfg();
            if (cyc >= m_end) begin
              m_start = 1; m_phase = S_SETTLE; m_end = cyc + SETTLE_WAIT;
            end
          end
        endcase
      end
      if (tmo) m_err = 1;
      else if (err_clr) m_err = 0;
      if (err_clr) begin m_scnt = 0; m_rcnt = 0; end
    end
    e.pdwn_n = m_pdwn; e.start = m_start; e.rx_en = m_rxen; e.ready = m_ready;
    e.out_valid = m_ov; e.timeout_err = m_err; e.ll_config = m_ll; e.drate = m_drate;
    e.state = m_phase;
`ifdef ADS1675_CTRL_STATS_EN
    e.scnt = 32'(m_scnt); e.rcnt = 16'(m_rcnt);
`else
    e.scnt = '0; e.rcnt = '0;
`endif
    ctl_q.push_back(e);
    cyc++;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wait_ready(input int bound);
    int n = 0;
    while (!ready && n < bound) begin cycle(); n++; end
    chk("wait_ready", 64'(ready), 64'd1);
  endtask

  // Monitor: compares every registered output once per cycle, and each sample
  initial begin
    ctl_t a, e;
    forever begin
      @(negedge clk);
      if (ctl_q.size() > 0) begin
        e = ctl_q.pop_front();
        a.pdwn_n = pdwn_n; a.start = start; a.rx_en = rx_en; a.ready = ready;
        a.out_valid = out_valid; a.timeout_err = timeout_err; a.ll_config = ll_config;
        a.drate = drate; a.state = state; a.scnt = sample_cnt; a.rcnt = restart_cnt;
        chk("ctl", 64'(a), 64'(e));
      end
      if (out_valid) begin
        if (data_q.size() == 0) chk("unexpected_sample", 64'(out_data), 64'hDEAD_0000_0000);
        else chk("out_data", 64'(out_data), 64'(data_q.pop_front()));
      end
    end
  end

  initial begin
    int  n;
    bit  dense;
    rst = 1; en = 0; cfg_update = 0; err_clr = 0; rx_valid = 0;
    rx_data = '0; drate_cfg = 3'b000; ll_cfg = 0;
    repeat (3) cycle();
    chk("reset_outputs", 64'({pdwn_n, start, rx_en, ready, out_valid, timeout_err,
                             ll_config, drate, state, out_data}), 64'd0);

    // Power-up timing; SETTLE samples must be swallowed
    rst = 0; en = 1; drate_cfg = 3'b010; ll_cfg = 1;
    for (int k = 1; k <= 25; k++) begin
      cycle();
      if (k == 1)  chk("pdwn_at_1", 64'(pdwn_n), 64'd1);
      if (k == 8)  chk("start_low_at_8", 64'(start), 64'd0);
      if (k == 9)  chk("start_at_9", 64'(start), 64'd1);
      if (k == 24) chk("ready_low_at_24", 64'(ready), 64'd0);
      if (k == 25) chk("ready_at_25", 64'({ready, state}), 64'({1'b1, S_RUN}));
      if (k >= 9 && k <= 24) chk("settle_no_out", 64'(out_valid), 64'd0);
      rx_valid = (k == 12 || k == 15);
      rx_data  = 24'h123456;
    end
    rx_valid = 1; rx_data = 24'hABCDEF;
    cycle();
    rx_valid = 0;
    chk("first_sample", 64'({out_valid, out_data}), 64'({1'b1, 24'hABCDEF}));

    // Stall recovery
    for (int i = 0; i < 5; i++) begin
      rx_valid = 1; rx_data = W'($urandom); cycle(); rx_valid = 0;
      if (i < 4) repeat (9) cycle();
    end
    n = 1;
    while (!timeout_err && n < 40) begin cycle(); n++; end
    chk("timeout_latency", 64'(n), 64'd21);
    chk("restart_start_low", 64'({start, ready}), 64'd0);
    n = 0;
    while (!start && n < 20) begin n++; cycle(); end
    chk("start_low_cycles", 64'(n), 64'(RESTART_LOW));
    wait_ready(40);
    err_clr = 1; cycle(); err_clr = 0;
    chk("err_clr", 64'(timeout_err), 64'd0);

    // Runtime data-rate change
    cfg_update = 1; drate_cfg = 3'b101; ll_cfg = 0;
    cycle();
    cfg_update = 0;
    chk("drate_applied", 64'({drate, ll_config, start, ready}), 64'({3'b101, 1'b0, 1'b0, 1'b0}));
    n = 0;
    while (!ready && n < 60) begin n++; cycle(); end
    chk("ready_low_cycles", 64'(n), 64'(RESTART_LOW + SETTLE_WAIT));

    // en dropped during SETTLE, then during RUN with a sample arriving
    cfg_update = 1; drate_cfg = 3'b011; cycle(); cfg_update = 0;
    repeat (7) cycle();
    chk("in_settle", 64'(state), 64'(S_SETTLE));
    en = 0; cycle();
    chk("en_off_settle", 64'({pdwn_n, start, rx_en, out_valid, ready, state}), 64'd0);
    en = 1;
    wait_ready(60);
    rx_valid = 1; rx_data = 24'h5A5A5A; en = 0; cycle();
    rx_valid = 0;
    chk("en_off_run", 64'({pdwn_n, start, rx_en, out_valid, ready, state}), 64'd0);
    chk("cfg_kept", 64'(drate), 64'd3);
    en = 1;

    // Statistics: five samples then one timeout
    wait_ready(60);
    err_clr = 1; cycle(); err_clr = 0;
    for (int i = 0; i < 5; i++) begin
      rx_valid = 1; rx_data = W'($urandom); cycle(); rx_valid = 0;
      repeat (2) cycle();
    end
    n = 0;
    while (!timeout_err && n < 40) begin cycle(); n++; end
`ifdef ADS1675_CTRL_STATS_EN
    chk("stats", 64'({sample_cnt, restart_cnt}), 64'({32'd5, 16'd1}));
`else
    chk("stats", 64'({sample_cnt, restart_cnt}), 64'd0);
`endif
    err_clr = 1; cycle(); err_clr = 0;

    // Random traffic with alternating busy and silent stretches
    dense = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) dense = ($urandom_range(0, 2) != 0);
      en         = ($urandom_range(0, 299) != 0);
      rx_valid   = dense && ($urandom_range(0, 5) == 0);
      rx_data    = W'($urandom);
      cfg_update = ($urandom_range(0, 199) == 0);
      err_clr    = ($urandom_range(0, 99) == 0);
      drate_cfg  = 3'($urandom);
      ll_cfg     = 1'($urandom);
      cycle();
    end
    en = 1; rx_valid = 0; cfg_update = 0; err_clr = 0;
    cycle();
    @(negedge clk);
    #1;
    chk("data_q_drained", 64'(data_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
